ram_io_responder: RTL and testbench

- Responder end of the byte-serial RAM port driven by the CPU memory controller.
- Contains a single-port byte RAM for addresses with addr_in[17:16] != 2'b11.
- Decodes the I/O region (addr_in[17:16] == 2'b11) into a TX byte FIFO with an io_buffer_full back-pressure flag, and optionally an RX FIFO.
- Sits between the memory controller and the board RAM/UART, and serves as the simulation RAM model.

---
 rtl/ram_io_responder_if.sv | 30 +++
 rtl/ram_io_responder.sv | 177 +++++++++++++++++
 tb/tb_ram_io_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_io_responder_if.sv
// ram_io_responder_if: CPU-side byte-serial RAM port plus the TX/RX byte streams.
// Handshake: a CPU access is accepted on any clk_in edge where rdy_in=1.
// A TX byte moves on any edge where tx_valid && tx_ready are both high.
// An RX byte is offered on every edge where rx_valid=1; there is no back-pressure.
interface ram_io_responder_if;
    logic        rdy_in;
    logic        rw_select;
    logic [17:0] addr_in;
    logic [7:0]  ram_store_data;
    logic [7:0]  ram_load_data;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_overflow;
    logic [7:0]  rx_data;
    logic        rx_valid;

    // The controller / UART side of the port.
    modport master (
        output rdy_in, rw_select, addr_in, ram_store_data, tx_ready, rx_data, rx_valid,
        input  ram_load_data, io_buffer_full, tx_data, tx_valid, tx_overflow
    );

    // The responder side of the port.
    modport slave (
        input  rdy_in, rw_select, addr_in, ram_store_data, tx_ready, rx_data, rx_valid,
        output ram_load_data, io_buffer_full, tx_data, tx_valid, tx_overflow
    );
endinterface

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM plus memory-mapped TX FIFO (0x30000 write) and
// status register (0x30004 read) behind the byte-serial RAM port.
// Optional feature macro IO_RX_EN: adds an RX FIFO popped by reads of 0x30000.
module ram_io_responder #(
    parameter int MEM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG   = 3,
    parameter int FULL_MARGIN    = 2,
    parameter int RX_DEPTH_LOG   = 3
) (
    input logic              clk_in,
    input logic              rst_in,
    ram_io_responder_if.slave bus
);
    localparam int                TXC_W        = TX_DEPTH_LOG + 1;
    localparam logic [TXC_W-1:0]  TX_DEPTH     = TXC_W'(2 ** TX_DEPTH_LOG);
    localparam logic [TXC_W-1:0]  TX_FULL_AT   = TXC_W'(2 ** TX_DEPTH_LOG - FULL_MARGIN);
    localparam logic [17:0]       IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0]       IO_STAT_ADDR = 18'h30004;

    logic [7:0] mem_q [2 ** MEM_ADDR_WIDTH];

    // Access decode; CPU-side effects only happen on accepted (rdy_in=1) cycles.
    logic is_io, cpu_wr, cpu_rd, tx_push_req, data_rd, read_edge;
    logic [17:0] last_addr_q;
    logic        last_rw_q;

    assign is_io       = bus.addr_in[17:16] == 2'b11;
    assign cpu_wr      = bus.rdy_in && bus.rw_select;
    assign cpu_rd      = bus.rdy_in && !bus.rw_select;
    assign tx_push_req = cpu_wr && (bus.addr_in == IO_DATA_ADDR);
    assign data_rd     = cpu_rd && (bus.addr_in == IO_DATA_ADDR);
    // A controller parked on 0x30000 must only consume one RX byte.
    assign read_edge   = data_rd && !(!last_rw_q && (last_addr_q == IO_DATA_ADDR));

    // Remember the previous accepted access for the read-pop edge rule.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_addr_q <= '0;
            last_rw_q   <= 1'b0;
        end else if (bus.rdy_in) begin
            last_addr_q <= bus.addr_in;
            last_rw_q   <= bus.rw_select;
        end
    end

    // Byte RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (cpu_wr && !is_io) begin
            mem_q[bus.addr_in[MEM_ADDR_WIDTH-1:0]] <= bus.ram_store_data;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]              tx_mem_q [2 ** TX_DEPTH_LOG];
    logic [TX_DEPTH_LOG-1:0] tx_wr_q, tx_rd_q;
    logic [TXC_W-1:0]        tx_count_q, tx_count_d;
    logic                    tx_pop, tx_push, tx_drop;
    logic                    tx_overflow_q, io_full_q;

    assign tx_pop  = (tx_count_q != '0) && bus.tx_ready;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign tx_push = tx_push_req && ((tx_count_q != TX_DEPTH) || tx_pop);
    assign tx_drop = tx_push_req && !tx_push;

    // Next TX occupancy from the push/pop pair.
    always_comb begin
        tx_count_d = tx_count_q;
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count_q + TXC_W'(1);
        end else if (!tx_push && tx_pop) begin
            tx_count_d = tx_count_q - TXC_W'(1);
        end
    end

    // TX pointers, count, near-full flag and sticky overflow.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            tx_count_q    <= '0;
            io_full_q     <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else begin
            tx_count_q <= tx_count_d;
            // Margin covers the controller's check-then-write lag.
            io_full_q  <= tx_count_d >= TX_FULL_AT;
            if (tx_push) tx_wr_q <= tx_wr_q + TX_DEPTH_LOG'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TX_DEPTH_LOG'(1);
            if (tx_drop) tx_overflow_q <= 1'b1;
        end
    end

    // TX storage write port.
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= bus.ram_store_data;
    end

    assign bus.tx_data        = tx_mem_q[tx_rd_q];
    assign bus.tx_valid       = tx_count_q != '0;
    assign bus.tx_overflow    = tx_overflow_q;
    assign bus.io_buffer_full = io_full_q;

    // ---------------- RX FIFO (optional) ----------------
    logic       rx_nonempty;
    logic [7:0] rx_head;

`ifdef IO_RX_EN
    localparam int               RXC_W    = RX_DEPTH_LOG + 1;
    localparam logic [RXC_W-1:0] RX_DEPTH = RXC_W'(2 ** RX_DEPTH_LOG);

    logic [7:0]              rx_mem_q [2 ** RX_DEPTH_LOG];
    logic [RX_DEPTH_LOG-1:0] rx_wr_q, rx_rd_q;
    logic [RXC_W-1:0]        rx_count_q;
    logic                    rx_pop, rx_push;

    assign rx_nonempty = rx_count_q != '0;
    assign rx_head     = rx_mem_q[rx_rd_q];
    assign rx_pop      = read_edge && rx_nonempty;
    assign rx_push     = bus.rx_valid && ((rx_count_q != RX_DEPTH) || rx_pop);

    // RX pointers and count; pushes ignore rdy_in.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_count_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + RX_DEPTH_LOG'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + RX_DEPTH_LOG'(1);
            if (rx_push && !rx_pop) begin
                rx_count_q <= rx_count_q + RXC_W'(1);
            end else if (!rx_push && rx_pop) begin
                rx_count_q <= rx_count_q - RXC_W'(1);
            end
        end
    end

    // RX storage write port.
    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= bus.rx_data;
    end
`else
    localparam int unused_rx_depth = RX_DEPTH_LOG;
    logic unused_rx;
    assign unused_rx   = ^{bus.rx_data, bus.rx_valid};
    assign rx_nonempty = 1'b0;
    assign rx_head     = 8'h00;
`endif

    // ---------------- Read data ----------------
    logic [7:0] load_q, load_d;

    // Read mux; writes and paused cycles hold the last value. A repeated read
    // of 0x30000 also holds, so it keeps showing the byte it popped.
    always_comb begin
        load_d = load_q;
        if (cpu_rd) begin
            if (!is_io) begin
                load_d = mem_q[bus.addr_in[MEM_ADDR_WIDTH-1:0]];
            end else if (bus.addr_in == IO_STAT_ADDR) begin
                load_d = {6'b0, rx_nonempty, io_full_q};
            end else if (bus.addr_in == IO_DATA_ADDR) begin
                if (read_edge) load_d = rx_nonempty ? rx_head : 8'h00;
            end else begin
                load_d = 8'h00;
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk_in) begin
        if (rst_in) load_q <= 8'h00;
        else        load_q <= load_d;
    end

    assign bus.ram_load_data = load_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed stimulus for ram_io_responder with a
// cycle-tagged expectation queue and a TX drain scoreboard.
module tb_ram_io_responder;
    localparam int K_LOAD  = 0;
    localparam int K_FULL  = 1;
    localparam int K_VALID = 2;
    localparam int K_OVF   = 3;
    localparam logic [17:0] A_DATA = 18'h30000;
    localparam logic [17:0] A_STAT = 18'h30004;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
        string      name;
    } chk_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    ram_io_responder_if bus();

    ram_io_responder dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    // ---------------- scoreboard ----------------
    chk_t       chk_q[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    chk_t       cur;
    logic [7:0] act;
    logic [7:0] tx_exp;

    always @(negedge clk) begin
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_pop: got %h, expected no byte", bus.tx_data);
            end else begin
                tx_exp = exp_q.pop_front();
                if (bus.tx_data !== tx_exp) begin
                    bad++;
                    $display("FAIL tx_pop: got %h expected %h", bus.tx_data, tx_exp);
                end
            end
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc_cnt) begin
            cur = chk_q.pop_front();
            case (cur.kind)
                K_LOAD:  act = bus.ram_load_data;
                K_FULL:  act = {7'b0, bus.io_buffer_full};
                K_VALID: act = {7'b0, bus.tx_valid};
                K_OVF:   act = {7'b0, bus.tx_overflow};
                default: act = 8'hxx;
            endcase
            total++;
            if (cur.cyc != cyc_cnt || act !== cur.val) begin
                bad++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         cur.name, act, cur.val, cyc_cnt, cur.cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rdy, input logic rw, input logic [17:0] addr,
                         input logic [7:0] wd);
        bus.rdy_in         = rdy;
        bus.rw_select      = rw;
        bus.addr_in        = addr;
        bus.ram_store_data = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Expectation for the outputs right after the edge that captures the
    // inputs currently being driven.
    task automatic expect_next(input int kind, input logic [7:0] val, input string name);
        chk_t c;
        c.cyc  = cyc_cnt + 1;
        c.kind = kind;
        c.val  = val;
        c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic wr(input logic [17:0] addr, input logic [7:0] wd);
        drive(1'b1, 1'b1, addr, wd);
        step();
    endtask

    task automatic rd(input logic [17:0] addr, input logic [7:0] exp, input string name);
        drive(1'b1, 1'b0, addr, 8'h00);
        expect_next(K_LOAD, exp, name);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.rdy_in = 1'b0; bus.rw_select = 1'b0; bus.addr_in = '0;
        bus.ram_store_data = 8'h00; bus.tx_ready = 1'b0;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        expect_next(K_LOAD,  8'h00, "rst_load");
        expect_next(K_FULL,  8'h00, "rst_full");
        expect_next(K_VALID, 8'h00, "rst_valid");
        expect_next(K_OVF,   8'h00, "rst_ovf");
        step();
        rst = 1'b0;

        // RAM write/read, 1-cycle latency, neighbour untouched, write holds load.
        wr(18'h00011, 8'h3C);
        wr(18'h00010, 8'hA5);
        rd(18'h00010, 8'hA5, "ram_rd_a5");
        rd(18'h00011, 8'h3C, "ram_rd_neighbour");
        drive(1'b1, 1'b1, 18'h00010, 8'h77);
        expect_next(K_LOAD, 8'h3C, "ram_wr_hold");
        step();
        rd(18'h00010, 8'h77, "ram_rd_77");

        // Fill TX FIFO with tx_ready low.
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, A_DATA, 8'(i));
            exp_q.push_back(8'(i));
            if (i == 5) expect_next(K_FULL, 8'h00, "full_after_5");
            if (i == 6) expect_next(K_FULL, 8'h01, "full_after_6");
            if (i == 8) begin
                expect_next(K_OVF,   8'h00, "ovf_at_8");
                expect_next(K_VALID, 8'h01, "valid_at_8");
            end
            step();
        end
        rd(A_STAT, 8'h01, "status_full");

        // Full FIFO: push and pop on the same edge.
        bus.tx_ready = 1'b1;
        drive(1'b1, 1'b1, A_DATA, 8'h0A);
        exp_q.push_back(8'h0A);
        expect_next(K_OVF,  8'h00, "ovf_push_pop_full");
        expect_next(K_FULL, 8'h01, "full_push_pop_full");
        step();
        bus.tx_ready = 1'b0;

        // Full FIFO: plain push is dropped.
        drive(1'b1, 1'b1, A_DATA, 8'h0B);
        expect_next(K_OVF, 8'h01, "ovf_drop");
        step();

        // Drain all eight entries.
        bus.tx_ready = 1'b1;
        drive(1'b1, 1'b0, 18'h00010, 8'h00);
        for (int i = 0; i < 8; i++) step();
        expect_next(K_VALID, 8'h00, "drained_valid");
        expect_next(K_FULL,  8'h00, "drained_full");
        expect_next(K_OVF,   8'h01, "ovf_sticky");
        expect_next(K_LOAD,  8'h77, "idle_load");
        step();

        // rdy_in low blocks CPU push/write and holds load; drain continues.
        bus.tx_ready = 1'b0;
        drive(1'b1, 1'b1, A_DATA, 8'h11);
        exp_q.push_back(8'h11);
        step();
        drive(1'b0, 1'b1, A_DATA, 8'h22);
        step();
        bus.tx_ready = 1'b1;
        drive(1'b0, 1'b0, 18'h00011, 8'h00);
        expect_next(K_LOAD, 8'h77, "rdy_low_hold");
        step();
        drive(1'b0, 1'b1, 18'h00010, 8'hEE);
        expect_next(K_VALID, 8'h00, "rdy_low_no_push");
        step();
        rd(18'h00010, 8'h77, "rdy_low_no_wr");

        // Other I/O addresses: writes ignored, reads return 0.
        drive(1'b1, 1'b1, 18'h30001, 8'h99);
        step();
        drive(1'b1, 1'b0, 18'h00010, 8'h00);
        expect_next(K_VALID, 8'h00, "io_other_wr");
        step();
        rd(18'h30008, 8'h00, "io_other_rd");

        // RX path.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h41;
        drive(1'b1, 1'b0, 18'h00010, 8'h00);
        step();
        bus.rx_data = 8'h42;
        step();
        bus.rx_valid = 1'b0;
`ifdef IO_RX_EN
        rd(A_STAT, 8'h02, "rx_status");
        rd(A_DATA, 8'h41, "rx_hold0");
        rd(A_DATA, 8'h41, "rx_hold1");
        rd(A_DATA, 8'h41, "rx_hold2");
        rd(18'h00010, 8'h77, "rx_away");
        rd(A_DATA, 8'h42, "rx_second");
        rd(18'h00010, 8'h77, "rx_away2");
        rd(A_DATA, 8'h00, "rx_empty");
        rd(A_STAT, 8'h00, "rx_status_empty");
`else
        rd(A_STAT, 8'h00, "status_no_rx");
        rd(A_DATA, 8'h00, "data_no_rx");
        rd(18'h00010, 8'h77, "rx_away");
        rd(A_DATA, 8'h00, "data_no_rx2");
`endif

        // Reset in the middle of a TX burst.
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, A_DATA, 8'(8'h50 + i));
            exp_q.push_back(8'(8'h50 + i));
            step();
        end
        drive(1'b1, 1'b0, 18'h00010, 8'h00);
        expect_next(K_LOAD,  8'h77, "pre_rst_load");
        expect_next(K_FULL,  8'h00, "pre_rst_full");
        expect_next(K_VALID, 8'h01, "pre_rst_valid");
        expect_next(K_OVF,   8'h01, "pre_rst_ovf");
        step();
        rst = 1'b1;
        exp_q.delete();
        expect_next(K_LOAD,  8'h00, "mid_rst_load");
        expect_next(K_FULL,  8'h00, "mid_rst_full");
        expect_next(K_VALID, 8'h00, "mid_rst_valid");
        expect_next(K_OVF,   8'h00, "mid_rst_ovf");
        step();
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        expect_next(K_VALID, 8'h00, "post_rst_empty");
        step();
        step();

        // Bounded wait for the scoreboard to empty.
        for (int i = 0; i < 20 && chk_q.size() > 0; i++) step();
        total++;
        if (chk_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d checks / %0d tx bytes pending, expected 0 / 0",
                     chk_q.size(), exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
